// File: rtl/array_input_ctrl_pkg.sv
// Shared definitions for array_input_ctrl: FSM state encoding, default sizes
// and the bit positions of the debug word.
package array_input_ctrl_pkg;

    localparam int unsigned DEF_ARRAY_SIZE = 16;
    localparam int unsigned DEF_NUM_SIZE   = 16;

    localparam int unsigned DEBUG_W       = 7;
    localparam int unsigned DBG_STATE_LSB = 0;
    localparam int unsigned DBG_STATE_W   = 3;
    localparam int unsigned DBG_MODE_BIT  = 3;
    localparam int unsigned DBG_ERR_BIT   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_SHOW  = 3'd4
    } state_t;

endpackage

// File: rtl/array_input_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level; pulse is registered.
// A level already high when reset releases is absorbed and never produces a pulse.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic prev;
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            armed <= 1'b1;
            pulse <= level & ~prev & armed;
        end
    end

endmodule

// File: rtl/array_input_ctrl.sv
// Button-driven editor for a small data array, CPU launch and result display.
// Optional RUN watchdog enabled by defining CTRL_TIMEOUT_EN.
module array_input_ctrl
    import array_input_ctrl_pkg::*;
#(
    parameter  int unsigned ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter  int unsigned NUM_SIZE   = DEF_NUM_SIZE,
    parameter  int unsigned TIMEOUT    = 1_000_000,
    localparam int unsigned IDX_W      = $clog2(ARRAY_SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_efct,
    input  logic                switch_efct,
    input  logic                confirm_efct,
    input  logic                go_lst_efct,
    input  logic                go_nxt_efct,
    input  logic [NUM_SIZE-1:0] sw_data,
    input  logic                cpu_done,
    input  logic [NUM_SIZE-1:0] cpu_result,
    output logic [IDX_W-1:0]    cur_index,
    output logic [NUM_SIZE-1:0] show_num,
    output logic                mem_we,
    output logic [IDX_W-1:0]    mem_addr,
    output logic [NUM_SIZE-1:0] mem_wdata,
    output logic                cpu_start,
    output logic [DEBUG_W-1:0]  debug
);

    state_t              state, nxt_state;
    logic                show_mode, nxt_mode;
    logic                err;
    logic                timeout_hit;
    logic [IDX_W-1:0]    nxt_index, idx_step;
    logic [NUM_SIZE-1:0] nxt_show, nxt_wdata, nxt_result, result, shadow_rd;
    logic [IDX_W-1:0]    nxt_addr;
    logic                nxt_we, nxt_start;
    logic [NUM_SIZE-1:0] shadow [ARRAY_SIZE];

    logic p_start, p_switch, p_confirm, p_lst, p_nxt;
    logic ev_start, ev_confirm, ev_nav, ev_switch;

    btn_edge u_start   (.clk(clk), .rst_n(rst_n), .level(start_efct),   .pulse(p_start));
    btn_edge u_switch  (.clk(clk), .rst_n(rst_n), .level(switch_efct),  .pulse(p_switch));
    btn_edge u_confirm (.clk(clk), .rst_n(rst_n), .level(confirm_efct), .pulse(p_confirm));
    btn_edge u_go_lst  (.clk(clk), .rst_n(rst_n), .level(go_lst_efct),  .pulse(p_lst));
    btn_edge u_go_nxt  (.clk(clk), .rst_n(rst_n), .level(go_nxt_efct),  .pulse(p_nxt));

    // Priority: start > confirm > navigation > switch; lower events are dropped
    assign ev_start   = p_start;
    assign ev_confirm = p_confirm & ~p_start;
    assign ev_nav     = (p_nxt | p_lst) & ~p_start & ~p_confirm;
    assign ev_switch  = p_switch & ~(p_start | p_confirm | p_nxt | p_lst);

    always_comb begin
        idx_step = cur_index;
        if (p_nxt && !p_lst) begin
            idx_step = (cur_index == IDX_W'(ARRAY_SIZE - 1)) ? '0 : cur_index + IDX_W'(1);
        end else if (p_lst && !p_nxt) begin
            idx_step = (cur_index == '0) ? IDX_W'(ARRAY_SIZE - 1) : cur_index - IDX_W'(1);
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_index  = cur_index;
        nxt_mode   = show_mode;
        nxt_we     = 1'b0;
        nxt_addr   = mem_addr;
        nxt_wdata  = mem_wdata;
        nxt_start  = 1'b0;
        nxt_result = result;
        nxt_show   = show_num;
        shadow_rd  = '0;

        case (state)
            ST_IDLE: begin
                if (ev_start) begin
                    nxt_state = ST_EDIT;
                    nxt_index = '0;
                    nxt_mode  = 1'b0;
                end
            end
            ST_EDIT: begin
                if (ev_start) begin
                    nxt_state = ST_RUN;
                    nxt_start = 1'b1;
                end else if (ev_confirm) begin
                    nxt_state = ST_WRITE;
                    nxt_we    = 1'b1;
                    nxt_addr  = cur_index;
                    nxt_wdata = sw_data;
                end else if (ev_nav) begin
                    nxt_index = idx_step;
                end else if (ev_switch) begin
                    nxt_mode = ~show_mode;
                end
            end
            ST_WRITE: nxt_state = ST_EDIT;
            ST_RUN: begin
                if (timeout_hit) begin
                    nxt_state  = ST_SHOW;
                    nxt_mode   = 1'b0;
                    nxt_result = '1;
                end else if (cpu_done) begin
                    nxt_state  = ST_SHOW;
                    nxt_mode   = 1'b0;
                    nxt_result = cpu_result;
                end
            end
            ST_SHOW: begin
                if (ev_start) begin
                    nxt_state = ST_RUN;
                    nxt_start = 1'b1;
                end else if (ev_confirm) begin
                    nxt_state = ST_IDLE;
                    nxt_mode  = 1'b0;
                end else if (ev_nav) begin
                    nxt_index = idx_step;
                    nxt_mode  = 1'b1;
                end else if (ev_switch) begin
                    nxt_mode = 1'b0;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        // Forward the write completing this cycle so the display never shows stale data
        shadow_rd = shadow[nxt_index];
        if (state == ST_WRITE && mem_addr == nxt_index) begin
            shadow_rd = mem_wdata;
        end

        case (nxt_state)
            ST_IDLE:           nxt_show = '0;
            ST_EDIT, ST_WRITE: nxt_show = nxt_mode ? shadow_rd : sw_data;
            ST_RUN:            nxt_show = show_num;
            ST_SHOW:           nxt_show = nxt_mode ? shadow_rd : nxt_result;
            default:           nxt_show = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur_index <= '0;
            show_mode <= 1'b0;
            show_num  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_start <= 1'b0;
            result    <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            state     <= nxt_state;
            cur_index <= nxt_index;
            show_mode <= nxt_mode;
            show_num  <= nxt_show;
            mem_we    <= nxt_we;
            mem_addr  <= nxt_addr;
            mem_wdata <= nxt_wdata;
            cpu_start <= nxt_start;
            result    <= nxt_result;
            if (state == ST_WRITE) begin
                shadow[mem_addr] <= mem_wdata;
            end
        end
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] run_cnt;

    // Counts cycles spent in RUN; restarts from zero on every launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            err     <= 1'b0;
        end else begin
            run_cnt <= (state == ST_RUN) ? run_cnt + CNT_W'(1) : '0;
            if (nxt_start) begin
                err <= 1'b0;
            end else if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign timeout_hit = (state == ST_RUN) && !cpu_done && (run_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    // TIMEOUT only matters when the watchdog is built
    assign unused_timeout = ^32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

    always_comb begin
        debug = '0;
        debug[DBG_STATE_LSB +: DBG_STATE_W] = state;
        debug[DBG_MODE_BIT] = show_mode;
        debug[DBG_ERR_BIT]  = err;
    end

endmodule

// File: tb/tb_array_input_ctrl.sv
// Self-checking bench for array_input_ctrl; expected memory writes and CPU
// launches are queued as stimulus is applied and popped when the DUT acts.
module tb_array_input_ctrl;

    localparam int unsigned AS = 16;
    localparam int unsigned NS = 16;
    localparam int unsigned IW = 4;

    localparam logic [4:0] B_START   = 5'b00001;
    localparam logic [4:0] B_SWITCH  = 5'b00010;
    localparam logic [4:0] B_CONFIRM = 5'b00100;
    localparam logic [4:0] B_LST     = 5'b01000;
    localparam logic [4:0] B_NXT     = 5'b10000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    btn;
    logic [NS-1:0] sw_data;
    logic          cpu_done;
    logic [NS-1:0] cpu_result;
    logic [IW-1:0] cur_index;
    logic [NS-1:0] show_num;
    logic          mem_we;
    logic [IW-1:0] mem_addr;
    logic [NS-1:0] mem_wdata;
    logic          cpu_start;
    logic [6:0]    debug;

    int checks = 0;
    int errors = 0;

    logic [IW+NS-1:0] wr_q[$];
    logic [IW-1:0]    start_q[$];
    logic [IW+NS-1:0] wr_e;
    logic [IW-1:0]    st_e;

    always #5 clk = ~clk;

    array_input_ctrl #(
        .ARRAY_SIZE(AS),
        .NUM_SIZE  (NS),
        .TIMEOUT   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_efct  (btn[0]),
        .switch_efct (btn[1]),
        .confirm_efct(btn[2]),
        .go_lst_efct (btn[3]),
        .go_nxt_efct (btn[4]),
        .sw_data     (sw_data),
        .cpu_done    (cpu_done),
        .cpu_result  (cpu_result),
        .cur_index   (cur_index),
        .show_num    (show_num),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_start   (cpu_start),
        .debug       (debug)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the edge at which the press takes effect
    task automatic press(input logic [4:0] m);
        @(posedge clk);
        #1 btn = m;
        repeat (2) @(posedge clk);
        #1 btn = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_idx"},   32'(cur_index), 32'd0);
        check({tag, "_show"},  32'(show_num),  32'd0);
        check({tag, "_we"},    32'(mem_we),    32'd0);
        check({tag, "_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_start"}, 32'(cpu_start), 32'd0);
        check({tag, "_debug"}, 32'(debug),     32'd0);
    endtask

    // Scoreboard consumers for the write port and the launch pulse
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'(mem_we), 32'd0);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(wr_e[IW+NS-1:NS]));
                check("wr_data", 32'(mem_wdata), 32'(wr_e[NS-1:0]));
            end
        end
        if (cpu_start === 1'b1) begin
            if (start_q.size() == 0) begin
                check("start_unexpected", 32'(cpu_start), 32'd0);
            end else begin
                st_e = start_q.pop_front();
                check("start_idx", 32'(cur_index), 32'(st_e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b1;
        btn        = '0;
        sw_data    = 16'h0042;
        cpu_done   = 1'b0;
        cpu_result = '0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        press(B_START);
        check("start_state", 32'(debug[2:0]), 32'd1);
        check("start_idx0",  32'(cur_index),  32'd0);
        check("edit_show_sw", 32'(show_num),  32'h0042);

        for (int i = 0; i < 16; i++) begin
            press(B_NXT);
            check("nxt_wrap", 32'(cur_index), 32'((i + 1) % 16));
        end
        press(B_LST);
        check("lst_wrap", 32'(cur_index), 32'd15);
        for (int i = 0; i < 4; i++) press(B_NXT);
        check("idx3", 32'(cur_index), 32'd3);

        sw_data = 16'h00A5;
        wr_q.push_back({4'd3, 16'h00A5});
        press(B_CONFIRM);
        check("write_state", 32'(debug[2:0]), 32'd2);
        cycles(1);
        check("back_edit", 32'(debug[2:0]), 32'd1);
        check("we_one_cycle", 32'(mem_we), 32'd0);
        sw_data = 16'h5A5A;
        press(B_SWITCH);
        check("mode1", 32'(debug[3]), 32'd1);
        check("show_shadow", 32'(show_num), 32'h00A5);
        press(B_SWITCH);
        check("show_sw", 32'(show_num), 32'h5A5A);

        press(B_NXT | B_LST);
        check("both_nav_idx", 32'(cur_index), 32'd3);

        start_q.push_back(4'd3);
        press(B_START | B_CONFIRM);
        check("start_over_confirm", 32'(debug[2:0]), 32'd3);
        sw_data = 16'h0BAD;
        cycles(2);
        check("run_hold_show", 32'(show_num), 32'h5A5A);
        press(B_NXT);
        check("run_ignore_idx", 32'(cur_index), 32'd3);
        check("run_ignore_state", 32'(debug[2:0]), 32'd3);
        cpu_result = 16'h1234;
        cpu_done   = 1'b1;
        cycles(1);
        cpu_done   = 1'b0;
        check("show_state", 32'(debug[2:0]), 32'd4);
        check("show_result", 32'(show_num), 32'h1234);

        press(B_LST);
        check("browse_idx", 32'(cur_index), 32'd2);
        check("browse_show0", 32'(show_num), 32'h0000);
        press(B_NXT);
        check("browse_showA5", 32'(show_num), 32'h00A5);
        press(B_SWITCH);
        check("result_view", 32'(show_num), 32'h1234);

        start_q.push_back(4'd3);
        press(B_START);
        check("relaunch_state", 32'(debug[2:0]), 32'd3);
        cpu_result = 16'h4321;
        cpu_done   = 1'b1;
        cycles(1);
        cpu_done   = 1'b0;
        check("relaunch_result", 32'(show_num), 32'h4321);
        press(B_CONFIRM);
        check("idle_state", 32'(debug[2:0]), 32'd0);
        check("idle_show", 32'(show_num), 32'd0);

        // Reset while the write is in flight, with start held through release
        press(B_START);
        sw_data = 16'h7777;
        press(B_CONFIRM);
        rst_n = 1'b0;
        btn   = B_START;
        #1 check_all_zero("rst_write");
        cycles(2);
        rst_n = 1'b1;
        cycles(5);
        check("held_start_idle", 32'(debug[2:0]), 32'd0);
        btn = '0;
        cycles(3);
        check("held_release_idle", 32'(debug[2:0]), 32'd0);

        press(B_START);
        start_q.push_back(4'd0);
        press(B_START);
        cycles(3);
        check("run_before_rst", 32'(debug[2:0]), 32'd3);
        rst_n = 1'b0;
        #1 check_all_zero("rst_run");
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        check("after_run_rst", 32'(debug[2:0]), 32'd0);

`ifdef CTRL_TIMEOUT_EN
        begin
            int n;
            press(B_START);
            start_q.push_back(4'd0);
            press(B_START);
            n = 0;
            while (debug[2:0] != 3'd4 && n < 50) begin
                @(posedge clk);
                #1 n++;
            end
            check("timeout_cycles", 32'(n), 32'd8);
            check("timeout_err", 32'(debug[4]), 32'd1);
            check("timeout_show", 32'(show_num), 32'hFFFF);
            start_q.push_back(4'd0);
            press(B_START);
            check("err_cleared", 32'(debug[4]), 32'd0);
            cpu_result = 16'h0055;
            cpu_done   = 1'b1;
            cycles(1);
            cpu_done   = 1'b0;
            check("post_timeout_result", 32'(show_num), 32'h0055);
            press(B_CONFIRM);
        end
`endif

        cycles(3);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("start_q_empty", 32'(start_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_input_ctrl.md
ARRAY_INPUT_CTRL -- requirements
Module: array_input_ctrl

Interface
REQ-001 Parameter ARRAY_SIZE, default 16: number of array entries; index width IDX_W = clog2(ARRAY_SIZE).
REQ-002 Parameter NUM_SIZE, default 16: data word width.
REQ-003 Parameter TIMEOUT, default 1_000_000: RUN watchdog limit in cycles; used only with CTRL_TIMEOUT_EN.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start_efct, switch_efct, confirm_efct, go_lst_efct, go_nxt_efct  in  1 each  debounced button levels.
REQ-007 sw_data  in  NUM_SIZE  board switch value.
REQ-008 cpu_done  in  1  CPU completion level.
REQ-009 cpu_result  in  NUM_SIZE  CPU result word.
REQ-010 cur_index  out  IDX_W  selected entry; drives the cue lights.
REQ-011 show_num  out  NUM_SIZE  value for the seven-segment display.
REQ-012 mem_we  out  1; mem_addr  out  IDX_W; mem_wdata  out  NUM_SIZE  data-memory write port.
REQ-013 cpu_start  out  1  one-cycle CPU launch pulse.
REQ-014 debug  out  7  {2'b00, err, show_mode, state[2:0]}.

Function
REQ-015 Each button SHALL be rising-edge detected with one register stage; a press SHALL act exactly once, and its effect SHALL be visible on outputs 2 clk edges after the level rises.
REQ-016 States: IDLE=0, EDIT=1, WRITE=2, RUN=3, SHOW=4; all other codes SHALL return to IDLE.
REQ-017 Event priority when edges coincide: start > confirm > go_nxt/go_lst > switch; lower events in that cycle SHALL be dropped.
REQ-018 Simultaneous go_nxt and go_lst SHALL leave cur_index unchanged.
REQ-019 IDLE: show_num=0. On start: go to EDIT with cur_index=0 and show_mode=0.
REQ-020 EDIT: go_nxt increments cur_index, wrapping ARRAY_SIZE-1 to 0; go_lst decrements it, wrapping 0 to ARRAY_SIZE-1.
REQ-021 EDIT: switch toggles show_mode; show_num = sw_data when show_mode=0, otherwise shadow[cur_index].
REQ-022 EDIT: confirm goes to WRITE.
REQ-023 WRITE: for exactly one cycle, mem_we=1, mem_addr=cur_index and mem_wdata=sw_data (sampled in that cycle); shadow[cur_index] is updated; then return to EDIT. All button edges in WRITE SHALL be dropped.
REQ-024 EDIT: start asserts cpu_start for one cycle and goes to RUN.
REQ-025 RUN: buttons are ignored; show_num holds its last value; cpu_done=1 goes to SHOW and latches cpu_result.
REQ-026 SHOW: show_num = latched result; go_nxt/go_lst browse cur_index with show_num = shadow[cur_index]; switch returns to the result view; confirm goes to IDLE; start re-launches the CPU (REQ-024).
REQ-027 mem_we and cpu_start SHALL be 0 in every cycle not named above.

Reset
REQ-028 When rst_n=0, asynchronously: state=IDLE, cur_index=0, show_num=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_start=0, show_mode=0, err=0, all shadow entries and edge registers 0.
REQ-029 Reset asserted mid-WRITE or mid-RUN SHALL abort the operation with no further write or pulse; a button held through reset release SHALL NOT produce an edge.

Configuration
REQ-030 Macro CTRL_TIMEOUT_EN defined: a counter runs in RUN; when it reaches TIMEOUT without cpu_done, go to SHOW with err=1 and show_num=all ones; err clears on the next cpu_start or on reset.
REQ-031 Macro CTRL_TIMEOUT_EN undefined: no counter is built, RUN waits indefinitely, and err is tied to 0.

Structure
REQ-032 The shared package holds the state encoding, the default ARRAY_SIZE/NUM_SIZE values, and the debug field positions.
REQ-033 One sub-module, btn_edge (register plus rising-edge pulse), is instantiated five times.

Verification
REQ-034 Reset, start, then 16 go_nxt presses -> cur_index steps 1..15 and wraps back to 0; one go_lst from 0 -> 15.
REQ-035 EDIT, index 3, sw_data=16'h00A5, confirm -> exactly one cycle with mem_we=1, addr=3, wdata=16'h00A5; switch -> show_num=16'h00A5.
REQ-036 Same-cycle go_nxt+go_lst -> index unchanged; same-cycle start+confirm -> RUN entered, no write.
REQ-037 start in EDIT -> one cpu_start pulse; cpu_done with cpu_result=16'h1234 -> SHOW, show_num=16'h1234; confirm -> IDLE.
REQ-038 rst_n low during WRITE or RUN -> all outputs 0 at once; held start through release -> state stays IDLE.
REQ-039 CTRL_TIMEOUT_EN with TIMEOUT=8, cpu_done never set -> SHOW after 8 cycles, debug[4]=1, show_num=16'hFFFF.
